match_reporter: RTL

//  Downstream stage of the Aho-Corasick table reader. Consumes one NOW_STATE per scanned

---
 rtl/match_reporter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/match_reporter.sv
// Aho-Corasick match reporter. Looks up each scanned state's pattern mask, splits it into one
// {position, pattern id} record per set bit, and queues the records in a show-ahead FIFO.
module match_reporter #(
  parameter int STATE_W    = 8,
  parameter int NUM_STATES = 32,
  parameter int NPAT       = 4,
  parameter int POS_W      = 16,
  parameter int FIFO_DEPTH = 8,
  // Output table image, entry s at bits [s*NPAT +: NPAT]; bit i of an entry = pattern id i.
  parameter logic [NUM_STATES*NPAT-1:0] TABLE_INIT = '0,
  localparam int ID_W = (NPAT > 1) ? $clog2(NPAT) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLR,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [STATE_W-1:0] NOW_STATE,
  input  logic               IN_LAST,
  output logic               MATCH_VALID,
  input  logic               MATCH_READY,
  output logic [POS_W-1:0]   MATCH_POS,
  output logic [ID_W-1:0]    MATCH_ID,
  output logic [15:0]        MATCH_COUNT,
  output logic               DONE
);

  // state  | meaning
  // IDLE   | waiting for the next scanned state, IN_READY high
  // EMIT   | pushing one record per cycle for the set bits of the held mask

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam int REC_W = POS_W + ID_W;

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  state_t state_q, state_n;

  logic [NPAT-1:0]  table_rom [NUM_STATES];
  logic [NPAT-1:0]  lookup_mask;
  logic [IDX_W-1:0] st_idx;

  logic             ready_en_q;
  logic [NPAT-1:0]  mask_q;
  logic [POS_W-1:0] pos_q;
  logic             last_q;
  logic [POS_W-1:0] pos_cnt_q;
  logic [15:0]      match_count_q;
  logic             done_q;

  logic             in_ready;
  logic             accept;
  logic             push;
  logic             pop;
  logic [ID_W-1:0]  low_idx;
  logic [NPAT-1:0]  mask_rest;
  logic             last_push;
  logic [REC_W-1:0] push_rec;

  logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] fcnt_q;
  logic [CNT_W-1:0] fcnt_after_pop;
  logic [CNT_W-1:0] fcnt_n;
  logic             full_q;
  logic [REC_W-1:0] head_q;

  for (genvar g = 0; g < NUM_STATES; g++) begin : g_rom
    assign table_rom[g] = TABLE_INIT[g*NPAT +: NPAT];
  end

  // States outside the table carry no patterns.
  assign st_idx      = NOW_STATE[IDX_W-1:0];
  assign lookup_mask = ({{(32-STATE_W){1'b0}}, NOW_STATE} < 32'(NUM_STATES)) ?
                       table_rom[st_idx] : '0;

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else if (CLR) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (accept && (lookup_mask != '0)) state_n = S_EMIT;
      S_EMIT: if (last_push) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs and record selection
  always_comb begin
    in_ready  = ready_en_q && (state_q == S_IDLE);
    accept    = IN_VALID && in_ready;
    push      = (state_q == S_EMIT) && !full_q;
    pop       = (fcnt_q != '0) && MATCH_READY;
    low_idx   = '0;
    for (int i = NPAT - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = ID_W'(i);
    end
    mask_rest = mask_q & (mask_q - NPAT'(1));
    last_push = push && (mask_rest == '0);
    push_rec  = {pos_q, low_idx};
  end

  // Input stage: captured mask, position bookkeeping, match counter, DONE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready_en_q    <= 1'b0;
      mask_q        <= '0;
      pos_q         <= '0;
      last_q        <= 1'b0;
      pos_cnt_q     <= '0;
      match_count_q <= '0;
      done_q        <= 1'b0;
    end else if (CLR) begin
      ready_en_q    <= 1'b0;
      mask_q        <= '0;
      pos_q         <= '0;
      last_q        <= 1'b0;
      pos_cnt_q     <= '0;
      match_count_q <= '0;
      done_q        <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        mask_q    <= lookup_mask;
        pos_q     <= pos_cnt_q;
        last_q    <= IN_LAST;
        pos_cnt_q <= IN_LAST ? '0 : pos_cnt_q + POS_W'(1);
      end else if (push) begin
        mask_q <= mask_rest;
      end
      if (push && (match_count_q != 16'hFFFF)) begin
        match_count_q <= match_count_q + 16'd1;
      end
      done_q <= (accept && (lookup_mask == '0) && IN_LAST) || (last_push && last_q);
    end
  end

  // FIFO occupancy after this cycle's pop and push
  always_comb begin
    fcnt_after_pop = fcnt_q - CNT_W'(pop);
    fcnt_n         = fcnt_after_pop + CNT_W'(push);
    rd_ptr_n       = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge CLK) begin
    if (push && !CLR) begin
      fifo_mem[wr_ptr_q] <= push_rec;
    end
  end

  // Head register tracks the entry at the read pointer; it keeps its value once empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      full_q   <= 1'b0;
      head_q   <= '0;
    end else if (CLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      full_q   <= 1'b0;
      head_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q <= rd_ptr_n;
      fcnt_q   <= fcnt_n;
      full_q   <= (fcnt_n == CNT_W'(FIFO_DEPTH));
      if (fcnt_after_pop == '0) begin
        if (push) head_q <= push_rec;
      end else begin
        head_q <= fifo_mem[rd_ptr_n];
      end
    end
  end

  assign IN_READY    = in_ready;
  assign MATCH_VALID = (fcnt_q != '0);
  assign MATCH_POS   = head_q[REC_W-1:ID_W];
  assign MATCH_ID    = head_q[ID_W-1:0];
  assign MATCH_COUNT = match_count_q;
  assign DONE        = done_q;

endmodule
